// File: rtl/vga_timing_pkg.sv
// Shared timing constants, state encoding and helpers for the VGA sync
// decoder (and the display controller that generates the same timing).
//   CNT_W / ERR_W     : coordinate and error-counter widths
//   *_DEF             : nominal 640x480@60 timing in pixel samples / lines
//   sync_state_e      : decoder lock state
//   sat_inc()         : coordinate increment that sticks at all-ones
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int ERR_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 10'h3FF;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_VIS_START_DEF = 144;
  localparam int H_VIS_END_DEF   = 783;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_VIS_START_DEF = 35;
  localparam int V_VIS_END_DEF   = 514;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Per-signal sync sampler: keeps the previous pix_en sample of one sync line
// and flags rising/falling edges on the current pix_en sample.
//   board_clk, Reset : clock, asynchronous active-high reset
//   pix_en_i         : pixel strobe; the sample register only moves on it
//   sync_i           : active-low sync input
//   rise_o, fall_o   : combinational edge flags, only asserted with pix_en_i
module vga_sync_edge (
  input  logic board_clk,
  input  logic Reset,
  input  logic pix_en_i,
  input  logic sync_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // Idle level of an active-low sync is high, so reset to 1 to avoid
  // reporting a spurious rising edge on the first sample.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      prev_q <= 1'b1;
    end else if (pix_en_i) begin
      prev_q <= sync_i;
    end
  end

  assign fall_o = pix_en_i &  prev_q & ~sync_i;
  assign rise_o = pix_en_i & ~prev_q &  sync_i;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel/line coordinates from a VGA hSync/vSync pair, checks the
// timing against the expected geometry and reports lock and error status.
//   board_clk, Reset        : clock, asynchronous active-high reset
//   pix_en                  : 1-in-4 pixel strobe; inputs sampled only on it
//   hSync, vSync            : active-low syncs
//   hc_rx, vc_rx            : recovered coordinates (saturate at 1023)
//   bright_rx               : visible-area flag, only while locked
//   line_start, frame_start : one-cycle pulses after the hSync-fall sample
//   locked                  : a full frame has been seen without error
//   err_cnt                 : saturating count of timing-error samples
module vga_timing_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_VIS_START = H_VIS_START_DEF,
  parameter int H_VIS_END   = H_VIS_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_VIS_START = V_VIS_START_DEF,
  parameter int V_VIS_END   = V_VIS_END_DEF
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             pix_en,
  input  logic             hSync,
  input  logic             vSync,
  output logic [CNT_W-1:0] hc_rx,
  output logic [CNT_W-1:0] vc_rx,
  output logic             bright_rx,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_VS     = CNT_W'(H_VIS_START);
  localparam logic [CNT_W-1:0] H_VE     = CNT_W'(H_VIS_END);
  localparam logic [CNT_W-1:0] V_VS     = CNT_W'(V_VIS_START);
  localparam logic [CNT_W-1:0] V_VE     = CNT_W'(V_VIS_END);
  // hc one below saturation: the next non-edge sample is the timeout.
  localparam logic [CNT_W-1:0] HC_PRE   = CNT_MAX - CNT_W'(1);

  logic h_rise, h_fall, v_fall, v_rise_unused;

  vga_sync_edge u_hsync_edge (
    .board_clk (board_clk),
    .Reset     (Reset),
    .pix_en_i  (pix_en),
    .sync_i    (hSync),
    .rise_o    (h_rise),
    .fall_o    (h_fall)
  );

  vga_sync_edge u_vsync_edge (
    .board_clk (board_clk),
    .Reset     (Reset),
    .pix_en_i  (pix_en),
    .sync_i    (vSync),
    .rise_o    (v_rise_unused),
    .fall_o    (v_fall)
  );

  sync_state_e      state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             vpend_q, vpend_d;
  logic             bright_q, bright_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             line_err, pulse_err, frame_err, err_any;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= SEARCH;
      hc_q          <= '0;
      vc_q          <= '0;
      err_cnt_q     <= '0;
      vpend_q       <= 1'b0;
      bright_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      err_cnt_q     <= err_cnt_d;
      vpend_q       <= vpend_d;
      bright_q      <= bright_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    err_cnt_d     = err_cnt_q;
    vpend_d       = vpend_q;
    bright_d      = bright_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    line_err      = 1'b0;
    pulse_err     = 1'b0;
    frame_err     = 1'b0;
    err_any       = 1'b0;

    if (pix_en) begin
      if (h_fall) begin
        hc_d         = '0;
        line_start_d = 1'b1;
        line_err     = (hc_q != H_LAST);
        // A vSync fall seen earlier in the line, or on this very sample,
        // marks this line as line 0 of a new frame.
        if (vpend_q || v_fall) begin
          vc_d          = '0;
          vpend_d       = 1'b0;
          frame_start_d = 1'b1;
          frame_err     = (vc_q != V_LAST);
        end else begin
          vc_d = sat_inc(vc_q);
        end
      end else begin
        hc_d = sat_inc(hc_q);
        // Flag the timeout only on the step into saturation, so a stuck
        // hSync produces one error rather than one per sample.
        line_err = (hc_q == HC_PRE);
        if (v_fall) begin
          vpend_d = 1'b1;
        end
      end

      // hc_d is the count including this sample, i.e. the low-pulse width.
      pulse_err = h_rise && (hc_d != H_SYNC_W);
      err_any   = (state_q != SEARCH) && (line_err || pulse_err || frame_err);

      if (err_any && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end

      case (state_q)
        SEARCH: begin
          if (frame_start_d) state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (err_any)            state_d = SEARCH;
          else if (frame_start_d) state_d = LOCKED;
        end
        LOCKED: begin
          if (err_any) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase

      bright_d = (state_d == LOCKED) &&
                 (hc_d >= H_VS) && (hc_d <= H_VE) &&
                 (vc_d >= V_VS) && (vc_d <= V_VE);
    end
  end

  assign hc_rx       = hc_q;
  assign vc_rx       = vc_q;
  assign err_cnt     = err_cnt_q;
  assign bright_rx   = bright_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);

endmodule
